// File: rtl/multi_digit_lock.sv
// multi_digit_lock: digit-entry combination lock with code change and lockout.
// Optional feature macro: LOCKOUT_TIMER_EN (timed exit from ALARM).
//
// Ports:
//   clock       : single clock, all state updates on the rising edge
//   reset       : asynchronous active-low reset
//   digit_in    : digit value sampled when enter is high
//   enter       : single-cycle pulse, captures a digit or relocks
//   change      : single-cycle pulse, requests or aborts a code change
//   open        : lock released (registered decode of OPEN)
//   alarm       : lockout active (registered decode of ALARM)
//   new_mode    : new-code entry mode (registered decode of NEW_CODE)
//   digit_count : digits captured in the current sequence
//   tries_left  : remaining attempts before lockout
module multi_digit_lock #(
    parameter int DIGIT_W        = 4,
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_CODE = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              enter,
    input  logic                              change,
    output logic                              open,
    output logic                              alarm,
    output logic                              new_mode,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic [3:0]                        tries_left
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [3:0]       TRIES = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        LOCKED,
        CHECK,
        OPEN,
        NEW_CODE,
        ALARM
    } state_t;

    state_t state, state_n;

    logic [CODE_W-1:0] code, code_n;
    logic [CODE_W-1:0] entry, entry_n;
    logic [CODE_W-1:0] shifted;
    logic [CNT_W-1:0]  count, count_n;
    logic [3:0]        fails, fails_n;

`ifdef LOCKOUT_TIMER_EN
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LW-1:0] LOCK_END = LW'(LOCKOUT_CYCLES - 1);

    logic [LW-1:0] lock_cnt, lock_cnt_n;
`endif

    // First digit entered ends up in the most significant position.
    assign shifted = (entry << DIGIT_W) | CODE_W'(digit_in);

    always_comb begin
        state_n = state;
        code_n  = code;
        entry_n = entry;
        count_n = count;
        fails_n = fails;
`ifdef LOCKOUT_TIMER_EN
        lock_cnt_n = '0;
`endif
        unique case (state)
            LOCKED: begin
                if (enter) begin
                    entry_n = shifted;
                    count_n = count + ONE;
                    if (count == LAST) begin
                        state_n = CHECK;
                    end
                end
            end
            CHECK: begin
                count_n = '0;
                if (entry == code) begin
                    fails_n = '0;
                    state_n = OPEN;
                end else begin
                    fails_n = fails + 4'd1;
                    if (fails + 4'd1 >= TRIES) begin
                        state_n = ALARM;
                    end else begin
                        state_n = LOCKED;
                    end
                end
            end
            OPEN: begin
                if (enter) begin
                    state_n = LOCKED;
                end else if (change) begin
                    state_n = NEW_CODE;
                    count_n = '0;
                    entry_n = '0;
                end
            end
            NEW_CODE: begin
                if (change) begin
                    state_n = OPEN;
                    count_n = '0;
                    entry_n = '0;
                end else if (enter) begin
                    if (count == LAST) begin
                        // Commit the full new code on the final digit.
                        code_n  = shifted;
                        entry_n = '0;
                        count_n = '0;
                        state_n = LOCKED;
                    end else begin
                        entry_n = shifted;
                        count_n = count + ONE;
                    end
                end
            end
            ALARM: begin
`ifdef LOCKOUT_TIMER_EN
                if (lock_cnt == LOCK_END) begin
                    state_n = LOCKED;
                    fails_n = '0;
                end else begin
                    lock_cnt_n = lock_cnt + LW'(1);
                end
`else
                state_n = ALARM;
`endif
            end
            default: begin
                state_n = LOCKED;
                count_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= LOCKED;
            code     <= RESET_CODE;
            entry    <= '0;
            count    <= '0;
            fails    <= '0;
            open     <= 1'b0;
            alarm    <= 1'b0;
            new_mode <= 1'b0;
        end else begin
            state    <= state_n;
            code     <= code_n;
            entry    <= entry_n;
            count    <= count_n;
            fails    <= fails_n;
            open     <= (state == OPEN);
            alarm    <= (state == ALARM);
            new_mode <= (state == NEW_CODE);
        end
    end

`ifdef LOCKOUT_TIMER_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt_n;
        end
    end
`endif

    assign digit_count = count;

    // Saturate so the count of remaining attempts never wraps.
    assign tries_left = (fails >= TRIES) ? 4'd0 : (TRIES - fails);

endmodule

// File: tb/tb_multi_digit_lock.sv
// tb_multi_digit_lock: directed bench for multi_digit_lock.
// Code 1234, lockout 8 clocks, other parameters default.
module tb_multi_digit_lock;

    logic       clock;
    logic       reset;
    logic [3:0] digit_in;
    logic       enter;
    logic       change;
    logic       open;
    logic       alarm;
    logic       new_mode;
    logic [2:0] digit_count;
    logic [3:0] tries_left;

    int n_tests;
    int n_fail;

    multi_digit_lock #(
        .DIGIT_W       (4),
        .NUM_DIGITS    (4),
        .MAX_TRIES     (3),
        .LOCKOUT_CYCLES(8),
        .RESET_CODE    (16'h1234)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .digit_in   (digit_in),
        .enter      (enter),
        .change     (change),
        .open       (open),
        .alarm      (alarm),
        .new_mode   (new_mode),
        .digit_count(digit_count),
        .tries_left (tries_left)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clock);
        digit_in = d;
        enter    = 1'b1;
        @(negedge clock);
        enter    = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            press(c[15-4*i -: 4]);
        end
    endtask

    task automatic pulse_change();
        @(negedge clock);
        change = 1'b1;
        @(negedge clock);
        change = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b0;
        digit_in = '0;
        enter    = 1'b0;
        change   = 1'b0;

        #1;
        check("rst_open", open, 0);
        check("rst_alarm", alarm, 0);
        check("rst_new", new_mode, 0);
        check("rst_count", digit_count, 0);
        check("rst_tries", tries_left, 3);
        @(negedge clock);
        reset = 1'b1;

        // Correct code, count progression and open latency.
        press(4'd1);
        check("cnt1", digit_count, 1);
        press(4'd2);
        check("cnt2", digit_count, 2);
        press(4'd3);
        check("cnt3", digit_count, 3);
        press(4'd4);
        check("cnt4", digit_count, 4);
        check("open_early", open, 0);
        @(negedge clock);
        check("open_1edge", open, 0);
        @(negedge clock);
        check("open_ok", open, 1);
        check("open_tries", tries_left, 3);
        check("open_cnt", digit_count, 0);

        press(4'd0);
        @(negedge clock);
        check("relock", open, 0);

        // Three wrong attempts lead to alarm.
        enter_code(16'h1235);
        @(negedge clock);
        check("fail1_tries", tries_left, 2);
        check("fail1_cnt", digit_count, 0);
        enter_code(16'h1235);
        @(negedge clock);
        check("fail2_tries", tries_left, 1);
        enter_code(16'h1235);
        @(negedge clock);
        check("fail3_tries", tries_left, 0);
        @(negedge clock);
        check("alarm_set", alarm, 1);
        press(4'd1);
        check("alarm_cnt", digit_count, 0);
        check("alarm_tries", tries_left, 0);
`ifdef LOCKOUT_TIMER_EN
        repeat (4) @(negedge clock);
        check("alarm_hold", alarm, 1);
        repeat (2) @(negedge clock);
        check("alarm_drop", alarm, 0);
        check("alarm_tries_back", tries_left, 3);
`else
        repeat (100) @(negedge clock);
        check("alarm_persist", alarm, 1);
        check("alarm_tries_hold", tries_left, 0);
`endif

        // Code change to 9876.
        do_reset();
        check("rec_alarm", alarm, 0);
        check("rec_tries", tries_left, 3);
        enter_code(16'h1234);
        repeat (2) @(negedge clock);
        check("chg_open", open, 1);
        pulse_change();
        @(negedge clock);
        check("chg_new", new_mode, 1);
        check("chg_open_off", open, 0);
        enter_code(16'h9876);
        @(negedge clock);
        check("chg_done_new", new_mode, 0);
        check("chg_done_open", open, 0);
        enter_code(16'h1234);
        @(negedge clock);
        check("old_code_fail", tries_left, 2);
        check("old_code_open", open, 0);
        enter_code(16'h9876);
        repeat (2) @(negedge clock);
        check("new_code_open", open, 1);
        check("new_code_tries", tries_left, 3);

        // Aborted change keeps the old code.
        do_reset();
        enter_code(16'h1234);
        repeat (2) @(negedge clock);
        pulse_change();
        press(4'd5);
        press(4'd6);
        check("abort_cnt2", digit_count, 2);
        pulse_change();
        @(negedge clock);
        check("abort_open", open, 1);
        check("abort_new", new_mode, 0);
        check("abort_cnt", digit_count, 0);
        press(4'd0);
        enter_code(16'h1234);
        repeat (2) @(negedge clock);
        check("abort_code_kept", open, 1);

        // Enter wins over change in OPEN.
        @(negedge clock);
        digit_in = 4'd0;
        enter    = 1'b1;
        change   = 1'b1;
        @(negedge clock);
        enter    = 1'b0;
        change   = 1'b0;
        @(negedge clock);
        check("both_open", open, 0);
        check("both_new", new_mode, 0);

        // Asynchronous reset mid-entry.
        press(4'd1);
        press(4'd2);
        check("mid_cnt", digit_count, 2);
        #2 reset = 1'b0;
        #1;
        check("arst_entry_cnt", digit_count, 0);
        check("arst_entry_tries", tries_left, 3);
        @(negedge clock);
        reset = 1'b1;

        // Asynchronous reset mid-change discards the partial code.
        enter_code(16'h1234);
        repeat (2) @(negedge clock);
        pulse_change();
        press(4'd9);
        press(4'd8);
        check("mid_new", new_mode, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_new", new_mode, 0);
        check("arst_new_cnt", digit_count, 0);
        check("arst_new_open", open, 0);
        @(negedge clock);
        reset = 1'b1;
        enter_code(16'h9876);
        @(negedge clock);
        check("discard_fail", tries_left, 2);
        check("discard_open", open, 0);
        enter_code(16'h1234);
        repeat (2) @(negedge clock);
        check("code_restored", open, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
